// File: rtl/polyplay_loader_pkg.sv
// polyplay_loader_pkg: shared state encoding and constants for the PolyPlay ROM loader
package polyplay_loader_pkg;
   typedef enum logic [1:0] {BOOT, LOAD, SETTLE, RUN} ldr_state_t;
   localparam logic [7:0] IDX_ROM = 8'd0;
   localparam logic [7:0] IDX_TNO = 8'd1;
   localparam int BCNT_W = 17;
endpackage

// File: rtl/polyplay_rom_loader_hold_timer.sv
// polyplay_hold_timer: loadable down-counter with zero flag, times the post-download settle delay
module polyplay_hold_timer #(
   parameter int W = 10
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;
   // load on request, otherwise count down and park at zero
   always_comb begin
      cnt_d = load_i ? val_i : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
   end
   // counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/polyplay_rom_loader.sv
// polyplay_rom_loader: ioctl download decoder, title latch and CPU hold for PolyPlay (optional checksum: POLYPLAY_ROM_CHECKSUM_EN)
module polyplay_rom_loader
   import polyplay_loader_pkg::*;
#(
   parameter int ROM_BYTES   = 32768,
   parameter int HOLD_CYCLES = 1024,
   parameter int ADDR_W      = 16
`ifdef POLYPLAY_ROM_CHECKSUM_EN
   , parameter logic [15:0] EXP_SUM = 16'h0000
`endif
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic              dn_wr,
   output logic [7:0]        tno,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
`ifdef POLYPLAY_ROM_CHECKSUM_EN
   , output logic [15:0]     rom_sum
`endif
);
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   ldr_state_t        state_q, state_d;
   logic              dl_q;
   logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
   logic [7:0]        dn_data_q, dn_data_d;
   logic              dn_wr_q, dn_wr_d;
   logic [7:0]        tno_q, tno_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;
   logic              rom_wr, in_range, accept, dl_rise, load_entry, load_exit, err, hold_zero;
`ifdef POLYPLAY_ROM_CHECKSUM_EN
   logic [15:0]       sum_q, sum_d;
`endif

   assign rom_wr     = (state_q == LOAD) && ioctl_wr && (ioctl_index == IDX_ROM);
   assign in_range   = ioctl_addr < 25'(ROM_BYTES);
   assign accept     = rom_wr && in_range;
   assign dl_rise    = ioctl_download && !dl_q && (ioctl_index == IDX_ROM);
   assign load_entry = (state_d == LOAD) && (state_q != LOAD);
   assign load_exit  = (state_q == LOAD) && !ioctl_download;

   // next-state logic: download start/end and settle expiry drive the sequencing
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:   if (ioctl_download && ioctl_index == IDX_ROM) state_d = LOAD;
         LOAD:   if (!ioctl_download) state_d = SETTLE;
         SETTLE: state_d = dl_rise ? LOAD : hold_zero ? RUN : SETTLE;
         RUN:    if (dl_rise) state_d = LOAD;
         default: state_d = BOOT;
      endcase
   end

   // datapath next values; the size check sees a write landing on the download fall
   always_comb begin
      byte_cnt_d = load_entry ? '0 : (accept && byte_cnt_q != '1) ? byte_cnt_q + BCNT_W'(1) : byte_cnt_q;
      ovf_d      = !load_entry && (ovf_q || (rom_wr && !in_range));
`ifdef POLYPLAY_ROM_CHECKSUM_EN
      sum_d      = load_entry ? 16'h0000 : accept ? sum_q + {8'h00, ioctl_dout} : sum_q;
      err        = ovf_d || (byte_cnt_d != BCNT_W'(ROM_BYTES)) || (sum_d != EXP_SUM);
`else
      err        = ovf_d || (byte_cnt_d != BCNT_W'(ROM_BYTES));
`endif
      load_err_d  = load_entry ? 1'b0 : load_exit ? err  : load_err_q;
      load_done_d = load_entry ? 1'b0 : load_exit ? !err : load_done_q;
      dn_wr_d     = accept;
      dn_addr_d   = accept ? ioctl_addr[ADDR_W-1:0] : dn_addr_q;
      dn_data_d   = accept ? ioctl_dout : dn_data_q;
      tno_d       = (ioctl_wr && ioctl_index == IDX_TNO && ioctl_addr == 25'd0) ? ioctl_dout : tno_q;
   end

   // state and datapath registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= BOOT;
         dl_q        <= 1'b0;
         byte_cnt_q  <= '0;
         ovf_q       <= 1'b0;
         dn_addr_q   <= '0;
         dn_data_q   <= '0;
         dn_wr_q     <= 1'b0;
         tno_q       <= '0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
`ifdef POLYPLAY_ROM_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         dl_q        <= ioctl_download;
         byte_cnt_q  <= byte_cnt_d;
         ovf_q       <= ovf_d;
         dn_addr_q   <= dn_addr_d;
         dn_data_q   <= dn_data_d;
         dn_wr_q     <= dn_wr_d;
         tno_q       <= tno_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
`ifdef POLYPLAY_ROM_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   polyplay_hold_timer #(.W(HOLD_W)) u_hold (
      .clk_i  (clk_sys),
      .rst_ni (reset_n),
      .load_i (load_exit),
      .val_i  (HOLD_W'(HOLD_CYCLES - 1)),
      .zero_o (hold_zero)
   );

   assign dn_addr   = dn_addr_q;
   assign dn_data   = dn_data_q;
   assign dn_wr     = dn_wr_q;
   assign tno       = tno_q;
   assign cpu_hold  = (state_q != RUN);
   assign load_done = load_done_q;
   assign load_err  = load_err_q;
`ifdef POLYPLAY_ROM_CHECKSUM_EN
   assign rom_sum   = sum_q;
`endif
endmodule

// File: tb/tb_polyplay_rom_loader.sv
// tb_polyplay_rom_loader: directed self-checking bench for the PolyPlay ROM loader
module tb_polyplay_rom_loader;
   localparam int ROM_BYTES = 32768;
   localparam int HOLD = 1024;

   logic        clk_sys = 1'b0, reset_n = 1'b0;
   logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
   logic [7:0]  ioctl_index = 8'd0, ioctl_dout = 8'd0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data, tno;
   logic        dn_wr, cpu_hold, load_done, load_err;
`ifdef POLYPLAY_ROM_CHECKSUM_EN
   logic [15:0] rom_sum;
`endif
   int checks = 0, errors = 0, pulses = 0;
   int bad, p0;

   polyplay_rom_loader #(
      .ROM_BYTES(ROM_BYTES), .HOLD_CYCLES(HOLD), .ADDR_W(16)
`ifdef POLYPLAY_ROM_CHECKSUM_EN
      , .EXP_SUM(16'h8000)
`endif
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
      .tno(tno), .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
`ifdef POLYPLAY_ROM_CHECKSUM_EN
      , .rom_sum(rom_sum)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) if (dn_wr === 1'b1) pulses++;

   initial begin
      #1_500_000;
      $display("FAIL timeout: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int a);
`ifdef POLYPLAY_ROM_CHECKSUM_EN
      return 8'h01;
`else
      return a[7:0];
`endif
   endfunction

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index = idx;
      ioctl_download = 1'b1;
      tick;
   endtask

   task automatic tno_wr(input logic [24:0] a, input logic [7:0] d);
      ioctl_wr = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      tick;
      ioctl_wr = 1'b0;
   endtask

   task automatic send(input int first, input int last, input bit fall_last, output int nbad);
      nbad = 0;
      for (int a = first; a <= last; a++) begin
         ioctl_wr = 1'b1;
         ioctl_addr = 25'(a);
         ioctl_dout = pat(a);
         if (fall_last && a == last) ioctl_download = 1'b0;
         tick;
         if (a < ROM_BYTES) begin
            if (dn_wr !== 1'b1 || dn_addr !== 16'(a) || dn_data !== pat(a)) nbad++;
         end else if (dn_wr !== 1'b0) nbad++;
      end
      ioctl_wr = 1'b0;
   endtask

   task automatic hold_chk(input string tag);
      chk({tag, " hold_at_fall"}, 32'(cpu_hold), 32'd1);
      tick;
      chk({tag, " dn_wr_single"}, 32'(dn_wr), 32'd0);
      repeat (HOLD - 2) tick;
      chk({tag, " hold_last"}, 32'(cpu_hold), 32'd1);
      tick;
      chk({tag, " hold_release"}, 32'(cpu_hold), 32'd0);
   endtask

   initial begin
      repeat (2) tick;
      chk("rst dn_addr", 32'(dn_addr), 32'd0);
      chk("rst dn_data", 32'(dn_data), 32'd0);
      chk("rst dn_wr", 32'(dn_wr), 32'd0);
      chk("rst tno", 32'(tno), 32'd0);
      chk("rst cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst load_done", 32'(load_done), 32'd0);
      chk("rst load_err", 32'(load_err), 32'd0);
      reset_n = 1'b1;
      repeat (5000) tick;
      chk("idle cpu_hold", 32'(cpu_hold), 32'd1);
      chk("idle load_done", 32'(load_done), 32'd0);
      chk("idle pulses", 32'(pulses), 32'd0);

      start_dl(8'd1);
      tno_wr(25'd0, 8'h05);
      tno_wr(25'd1, 8'h09);
      ioctl_download = 1'b0;
      tick;
      start_dl(8'd2);
      tno_wr(25'd0, 8'h33);
      ioctl_download = 1'b0;
      tick;
      chk("tno boot", 32'(tno), 32'h05);
      chk("tno pulses", 32'(pulses), 32'd0);
      chk("tno cpu_hold", 32'(cpu_hold), 32'd1);

      p0 = pulses;
      start_dl(8'd0);
      chk("full load hold", 32'(cpu_hold), 32'd1);
      send(0, ROM_BYTES - 1, 1'b1, bad);
      chk("full writes", 32'(bad), 32'd0);
      chk("full load_done", 32'(load_done), 32'd1);
      chk("full load_err", 32'(load_err), 32'd0);
`ifdef POLYPLAY_ROM_CHECKSUM_EN
      chk("full rom_sum", 32'(rom_sum), 32'h8000);
`endif
      hold_chk("full");
      chk("full pulses", 32'(pulses - p0), 32'(ROM_BYTES));

      start_dl(8'd0);
      chk("short rerun hold", 32'(cpu_hold), 32'd1);
      chk("short done cleared", 32'(load_done), 32'd0);
      send(0, 99, 1'b0, bad);
      ioctl_download = 1'b0;
      tick;
      chk("short writes", 32'(bad), 32'd0);
      chk("short load_err", 32'(load_err), 32'd1);
      chk("short load_done", 32'(load_done), 32'd0);
      hold_chk("short");

      start_dl(8'd0);
      chk("ovf err cleared", 32'(load_err), 32'd0);
      p0 = pulses;
      send(0, ROM_BYTES, 1'b0, bad);
      chk("ovf writes", 32'(bad), 32'd0);
      chk("ovf dn_addr held", 32'(dn_addr), 32'h7FFF);
      chk("ovf dn_data held", 32'(dn_data), 32'(pat(ROM_BYTES - 1)));
      ioctl_download = 1'b0;
      tick;
      chk("ovf load_err", 32'(load_err), 32'd1);
      chk("ovf load_done", 32'(load_done), 32'd0);
      hold_chk("ovf");
      chk("ovf pulses", 32'(pulses - p0), 32'(ROM_BYTES));

      start_dl(8'd1);
      tno_wr(25'd0, 8'h07);
      chk("tno run cpu_hold", 32'(cpu_hold), 32'd0);
      ioctl_download = 1'b0;
      tick;
      chk("tno run", 32'(tno), 32'h07);
      chk("tno run hold after", 32'(cpu_hold), 32'd0);

      start_dl(8'd0);
      chk("rerun hold next cycle", 32'(cpu_hold), 32'd1);
      send(0, 199, 1'b0, bad);
      chk("mid writes", 32'(bad), 32'd0);
      chk("mid dn_wr live", 32'(dn_wr), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async dn_wr kill", 32'(dn_wr), 32'd0);
      chk("async dn_addr", 32'(dn_addr), 32'd0);
      chk("async dn_data", 32'(dn_data), 32'd0);
      chk("async tno", 32'(tno), 32'd0);
      chk("async cpu_hold", 32'(cpu_hold), 32'd1);
      chk("async load_done", 32'(load_done), 32'd0);
      chk("async load_err", 32'(load_err), 32'd0);
      ioctl_download = 1'b0;
      tick;
      reset_n = 1'b1;
      repeat (HOLD + 10) tick;
      chk("boot after reset hold", 32'(cpu_hold), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/polyplay_rom_loader.md
Name: polyplay_rom_loader

Overview:
- Sits between hps_io's ioctl download port and the PolyPlay machine core.
- Decodes the MiSTer download stream into registered ROM write strobes (`dn_addr`/`dn_data`/`dn_wr`).
- Latches the title number from index-1 downloads.
- Holds the CPU in reset from power-up until a complete ROM image has loaded and a settle delay has expired; flags short or oversize images.

Parameters:
- ROM_BYTES, 32768: expected index-0 image size in bytes; must be ≤ 65536.
- HOLD_CYCLES, 1024: clk_sys cycles `cpu_hold` stays high after a download ends; must be ≥ 1.
- ADDR_W, 16: width of `dn_addr`.

Ports:
- clk_sys  in  1  system clock; all logic in this domain.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  high while hps_io transfers a file.
- ioctl_index  in  8  file index: 0 = ROM image, 1 = title-number file.
- ioctl_wr  in  1  one-cycle byte-valid strobe.
- ioctl_addr  in  25  byte offset within the current file.
- ioctl_dout  in  8  byte data.
- dn_addr  out  ADDR_W  ROM write address.
- dn_data  out  8  ROM write data.
- dn_wr  out  1  one-cycle ROM write strobe.
- tno  out  8  latched title number.
- cpu_hold  out  1  high = core held in reset.
- load_done  out  1  high once a correctly sized ROM has loaded.
- load_err  out  1  high if the last index-0 download was short or overran ROM_BYTES.

Behaviour:
- Reset values: `dn_addr`=0, `dn_data`=0, `dn_wr`=0, `tno`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0. FSM goes to BOOT; counters clear.
- FSM states: BOOT, LOAD, SETTLE, RUN.
  - BOOT: wait for `ioctl_download` with index 0, then go to LOAD.
  - LOAD: entry clears `byte_cnt`, `load_err` and the overflow flag; `cpu_hold`=1. When `ioctl_download` falls, go to SETTLE.
  - SETTLE: load `hold_cnt` = HOLD_CYCLES−1; decrement once per cycle; on 0, go to RUN.
  - RUN: `cpu_hold`=0.
  - A new index-0 download rising in SETTLE or RUN returns to LOAD in the next cycle; `cpu_hold` re-asserts in that same cycle.
- Write path (index 0, state LOAD, `ioctl_wr`=1):
  - If `ioctl_addr` < ROM_BYTES: register `dn_addr`=`ioctl_addr[ADDR_W-1:0]` and `dn_data`=`ioctl_dout`, pulse `dn_wr` for exactly one cycle (latency 1 cycle), and increment `byte_cnt` (17-bit, saturating).
  - Otherwise: drop the write (`dn_wr` stays 0) and set the overflow flag.
  - `dn_addr`/`dn_data` hold their last values when `dn_wr`=0.
- `ioctl_wr` outside LOAD or with index ≥ 2: ignored.
- Title number: index 1, `ioctl_wr`, `ioctl_addr`=0 → `tno` <= `ioctl_dout`. Accepted in any state. Nonzero offsets are ignored. `tno` does not affect `cpu_hold`.
- On leaving LOAD (download fall):
  - `load_err` <= overflow OR (`byte_cnt` ≠ ROM_BYTES).
  - `load_done` <= NOT that same error value.
  - Both hold until the next LOAD entry, which clears both.
- A short or oversize image still proceeds SETTLE→RUN; `load_err` is advisory.
- Download fall and `ioctl_wr` in the same cycle: the write is still accepted and counted before the size check.
- Asynchronous reset mid-LOAD: any in-flight `dn_wr` is killed immediately, FSM returns to BOOT, `cpu_hold`=1.

Optional Feature:
- Macro: POLYPLAY_ROM_CHECKSUM_EN.
- With it defined:
  - Adds output `rom_sum` [15:0] and parameter EXP_SUM (default 16'h0000).
  - `rom_sum` is the modulo-2^16 sum of every accepted byte of the current download; it clears on LOAD entry.
  - On download end, `load_err` additionally sets when `rom_sum` ≠ EXP_SUM, and `load_done` follows the combined error.
- Without it: no `rom_sum` port or adder; error = size/overflow only.

Decomposition:
- Package `polyplay_loader_pkg`:
  - state enum `ldr_state_t` {BOOT, LOAD, SETTLE, RUN};
  - constants IDX_ROM=8'd0, IDX_TNO=8'd1;
  - `byte_cnt` width constant (17).
- One natural sub-module: `polyplay_hold_timer`, a loadable down-counter with a zero flag, used for the SETTLE delay.
- Everything else stays inline.

Test Plan:
- Power-up, no download for 5000 cycles → `cpu_hold`=1, `load_done`=0, `dn_wr` never asserted.
- Full 32768-byte index-0 download, data = addr[7:0] → 32768 `dn_wr` pulses, each exactly 1 cycle after its `ioctl_wr` with matching addr/data. `load_done`=1 and `load_err`=0 at download fall; `cpu_hold` falls exactly HOLD_CYCLES (1024) cycles after download fall (±1 per FSM registration, checked exactly against the RTL).
- Short download of 100 bytes → `load_err`=1, `load_done`=0; `cpu_hold` still releases after 1024 cycles.
- Download writing addresses 0..32768 → byte at 32768 is dropped (no `dn_wr`), `load_err`=1.
- Index-1 write 0x05 at addr 0, then 0x09 at addr 1 → `tno`=0x05; no `dn_wr`; `cpu_hold` unchanged.
- While in RUN, start a second index-0 download and pull `reset_n` low halfway through → `cpu_hold`=1 the next cycle after download start; on reset, all outputs return to reset values and the FSM is in BOOT. Rerun with POLYPLAY_ROM_CHECKSUM_EN and all-0x01 data → `rom_sum`=16'h8000.
